// File: rtl/accelbrot_pkg.sv
// Shared types for the accelbrot pixel scan generator.
// Holds the scan FSM states and word-index sizing.
package accelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    BURST
  } state_e;

  function automatic int widx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accelbrot_scan_gen_if.sv
// Word-serial pixel handoff into the iteration loop.
// Master drives words, slave returns backpressure.
interface accelbrot_scan_gen_if #(
  parameter int WWIDTH = 34,
  parameter int TWIDTH = 24
);
  logic [WWIDTH-1:0] enter_a;
  logic [WWIDTH-1:0] enter_b;
  logic [TWIDTH-1:0] enter_tag;
  logic              enter_start;
  logic              enter_valid;
  logic              enter_bp;

  modport master (
    output enter_a, enter_b, enter_tag,
    output enter_start, enter_valid,
    input  enter_bp
  );

  modport slave (
    input  enter_a, enter_b, enter_tag,
    input  enter_start, enter_valid,
    output enter_bp
  );
endinterface

// File: rtl/accelbrot_serial_addsub.sv
// One word of a multi-word add/subtract.
// Carry is kept between words; first word seeds it.
module accelbrot_serial_addsub #(
  parameter int WWIDTH = 34
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              first_i,
  input  logic              sub_i,
  input  logic [WWIDTH-1:0] x_i,
  input  logic [WWIDTH-1:0] y_i,
  output logic [WWIDTH-1:0] s_o
);
  logic              c_q;
  logic              cin;
  logic              co;
  logic [WWIDTH-1:0] y_op;

  assign y_op = sub_i ? ~y_i : y_i;
  assign cin  = first_i ? sub_i : c_q;
  assign {co, s_o} = {1'b0, x_i} + {1'b0, y_op}
                   + {{WWIDTH{1'b0}}, cin};

  // carry chains from one word to the next
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) c_q <= 1'b0;
    else if (en_i) c_q <= co;
  end
endmodule

// File: rtl/accelbrot_scan_gen.sv
// Walks the pixel grid and streams (a, b) per pixel
// as word bursts, stepping coordinates word-serially.
module accelbrot_scan_gen
  import accelbrot_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int WWIDTH = 34,
  parameter int TWIDTH = 24,
  parameter int XWIDTH = 12,
  parameter int YWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NWORDS*WWIDTH-1:0] cfg_a0,
  input  logic [NWORDS*WWIDTH-1:0] cfg_b0,
  input  logic [NWORDS*WWIDTH-1:0] cfg_step,
  input  logic [XWIDTH-1:0]        cfg_width,
  input  logic [YWIDTH-1:0]        cfg_height,
  input  logic                     ctl_start,
  output logic                     ctl_busy,
  output logic                     ctl_done,
  output logic [31:0]              sts_num_issued,
  accelbrot_scan_gen_if.master     enter
);
  localparam int NB = NWORDS * WWIDTH;
  localparam int WB = widx_bits(NWORDS);
  localparam logic [WB-1:0] WLAST = WB'(NWORDS - 1);

  state_e            state_q;
  logic [NB-1:0]     a_cur_q, a_row0_q;
  logic [NB-1:0]     b_cur_q, step_q;
  logic [XWIDTH-1:0] width_q, x_q;
  logic [YWIDTH-1:0] height_q, y_q;
  logic [TWIDTH-1:0] tag_q, etag_q;
  logic [WB-1:0]     widx_q;
  logic [31:0]       issued_q;
  logic              busy_q, done_q;
  logic [WWIDTH-1:0] ea_q, eb_q;
  logic              estart_q, evalid_q;

  logic              first, shift, eor, last_px;
  logic [WWIDTH-1:0] a_lo, b_lo, s_lo, r_lo;
  logic [WWIDTH-1:0] a_sum, b_dif, a_new, b_new;

  assign a_lo = a_cur_q[WWIDTH-1:0];
  assign b_lo = b_cur_q[WWIDTH-1:0];
  assign s_lo = step_q[WWIDTH-1:0];
  assign r_lo = a_row0_q[WWIDTH-1:0];

  assign first = (state_q == ARM);
  assign shift = (first && !enter.enter_bp)
              || (state_q == BURST && widx_q != WLAST);
  assign eor     = (x_q == width_q - XWIDTH'(1));
  assign last_px = eor && (y_q == height_q - YWIDTH'(1));
  assign a_new   = eor ? r_lo : a_sum;
  assign b_new   = eor ? b_dif : b_lo;

  accelbrot_serial_addsub #(.WWIDTH(WWIDTH)) u_add_a (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (shift),
    .first_i (first),
    .sub_i   (1'b0),
    .x_i     (a_lo),
    .y_i     (s_lo),
    .s_o     (a_sum)
  );

  accelbrot_serial_addsub #(.WWIDTH(WWIDTH)) u_sub_b (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (shift),
    .first_i (first),
    .sub_i   (1'b1),
    .x_i     (b_lo),
    .y_i     (s_lo),
    .s_o     (b_dif)
  );

  // scan FSM, coordinate rotation and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      a_cur_q  <= '0;
      a_row0_q <= '0;
      b_cur_q  <= '0;
      step_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      tag_q    <= '0;
      etag_q   <= '0;
      widx_q   <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      estart_q <= 1'b0;
      evalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (shift) begin
        a_cur_q  <= {a_new, a_cur_q[NB-1:WWIDTH]};
        b_cur_q  <= {b_new, b_cur_q[NB-1:WWIDTH]};
        a_row0_q <= {r_lo, a_row0_q[NB-1:WWIDTH]};
        step_q   <= {s_lo, step_q[NB-1:WWIDTH]};
        ea_q     <= a_lo;
        eb_q     <= b_lo;
        estart_q <= first;
        evalid_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (ctl_start) begin
            if (cfg_width != '0 && cfg_height != '0) begin
              a_cur_q  <= cfg_a0;
              a_row0_q <= cfg_a0;
              b_cur_q  <= cfg_b0;
              step_q   <= cfg_step;
              width_q  <= cfg_width;
              height_q <= cfg_height;
              x_q      <= '0;
              y_q      <= '0;
              tag_q    <= '0;
              issued_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= ARM;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ARM: begin
          if (!enter.enter_bp) begin
            widx_q  <= '0;
            etag_q  <= tag_q;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (widx_q == WLAST) begin
            evalid_q <= 1'b0;
            estart_q <= 1'b0;
            issued_q <= issued_q + 32'd1;
            tag_q    <= tag_q + TWIDTH'(1);
            if (eor) begin
              x_q <= '0;
              y_q <= y_q + YWIDTH'(1);
            end else begin
              x_q <= x_q + XWIDTH'(1);
            end
            if (last_px) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= ARM;
            end
          end else begin
            widx_q <= widx_q + WB'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctl_busy          = busy_q;
  assign ctl_done          = done_q;
  assign sts_num_issued    = issued_q;
  assign enter.enter_a     = ea_q;
  assign enter.enter_b     = eb_q;
  assign enter.enter_tag   = etag_q;
  assign enter.enter_start = estart_q;
  assign enter.enter_valid = evalid_q;
endmodule

// File: tb/tb_accelbrot_scan_gen.sv
// Bench for accelbrot_scan_gen: directed table,
// backpressure/reset sequences, random scans vs model.
module tb_accelbrot_scan_gen;
  localparam int NW = 2;
  localparam int WW = 8;
  localparam int TW = 24;
  localparam int XW = 12;
  localparam int YW = 12;

  typedef struct {
    logic [15:0] a0, b0, st;
    int          w, h;
    int          n;
    logic [15:0] la, lb;
  } vec_t;

  typedef struct {
    logic [15:0] a, b;
    logic [23:0] tag;
  } px_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [15:0]   cfg_a0 = '0;
  logic [15:0]   cfg_b0 = '0;
  logic [15:0]   cfg_step = '0;
  logic [XW-1:0] cfg_width = '0;
  logic [YW-1:0] cfg_height = '0;
  logic          ctl_start = 1'b0;
  logic          ctl_busy, ctl_done;
  logic [31:0]   sts;

  int  n_vec = 0;
  int  n_err = 0;
  px_t got[$];

  accelbrot_scan_gen_if #(.WWIDTH(WW), .TWIDTH(TW)) enter ();

  accelbrot_scan_gen #(
    .NWORDS(NW), .WWIDTH(WW), .TWIDTH(TW),
    .XWIDTH(XW), .YWIDTH(YW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_a0         (cfg_a0),
    .cfg_b0         (cfg_b0),
    .cfg_step       (cfg_step),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .ctl_start      (ctl_start),
    .ctl_busy       (ctl_busy),
    .ctl_done       (ctl_done),
    .sts_num_issued (sts),
    .enter          (enter)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // burst monitor: assembles pixels, checks framing
  bit          inb = 1'b0;
  logic [15:0] ma, mb;
  logic [23:0] mtag;
  always @(negedge clk) begin
    if (!rstn) begin
      inb = 1'b0;
    end else if (inb) begin
      chk("burst_cont", enter.enter_valid, 1);
      chk("start_mid", enter.enter_start, 0);
      chk("tag_hold", enter.enter_tag, mtag);
      ma[15:8] = enter.enter_a;
      mb[15:8] = enter.enter_b;
      got.push_back('{a: ma, b: mb, tag: mtag});
      inb = 1'b0;
    end else if (enter.enter_valid) begin
      chk("start_w0", enter.enter_start, 1);
      ma[7:0] = enter.enter_a;
      mb[7:0] = enter.enter_b;
      mtag    = enter.enter_tag;
      inb     = 1'b1;
    end
  end

  // mode 0: no bp, 1: random bp, 2: held then mid-burst bp
  task automatic run_scan(input logic [15:0] a0,
                          input logic [15:0] b0,
                          input logic [15:0] st,
                          input int w, input int h,
                          input int mode);
    int n, cyc, fv, lv, dc, nd, m, x, y;
    bit anyb;
    logic [15:0] ea, eb;
    n = w * h;
    cyc = 0; fv = -1; lv = -1; dc = -1; nd = 0;
    anyb = 1'b0;
    got.delete();
    @(negedge clk);
    cfg_a0 = a0; cfg_b0 = b0; cfg_step = st;
    cfg_width = XW'(w); cfg_height = YW'(h);
    enter.enter_bp = (mode == 2);
    ctl_start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        ctl_start = 1'b0;
        if (n > 0) begin
          cfg_a0 = 16'($urandom);
          cfg_b0 = 16'($urandom);
          cfg_step = 16'($urandom);
          cfg_width = XW'($urandom_range(0, 5));
          cfg_height = YW'($urandom_range(0, 5));
        end
      end
      if (cyc == 2 && n > 0) ctl_start = 1'b1;
      if (cyc == 3) ctl_start = 1'b0;
      if (enter.enter_valid) begin
        if (fv < 0) fv = cyc;
        lv = cyc;
      end
      if (ctl_busy) anyb = 1'b1;
      if (ctl_done) begin
        nd++;
        if (dc < 0) begin
          dc = cyc;
          chk("busy_at_done", ctl_busy, 0);
          if (n > 0) chk("sts_issued", sts, n);
        end
      end
      case (mode)
        1:       enter.enter_bp = ($urandom_range(0, 2) == 0);
        2:       enter.enter_bp = (cyc <= 4) || (cyc == 6);
        default: enter.enter_bp = 1'b0;
      endcase
      if (dc >= 0 && cyc >= dc + 3) break;
      if (cyc >= 3000) break;
    end
    enter.enter_bp = 1'b0;
    chk("done_seen", (dc >= 0), 1);
    chk("done_once", nd, 1);
    if (n == 0) begin
      chk("zero_no_valid", fv, -1);
      chk("zero_no_busy", anyb, 0);
      chk("zero_done_lat", dc, 1);
    end else begin
      chk("done_after_last", dc, lv + 1);
      chk("n_pixels", got.size(), n);
      if (mode == 0) begin
        chk("first_latency", fv, 2);
        chk("pixel_period", lv, 3 * n);
      end
      if (mode == 2) chk("bp_release", fv, 6);
      m = (got.size() < n) ? got.size() : n;
      for (int i = 0; i < m; i++) begin
        x  = i % w;
        y  = i / w;
        ea = a0 + 16'(x) * st;
        eb = b0 - 16'(y) * st;
        chk("px_a", got[i].a, ea);
        chk("px_b", got[i].b, eb);
        chk("px_tag", got[i].tag, i);
      end
    end
  endtask

  vec_t vt[4];
  int   wcnt;

  initial begin
    enter.enter_bp = 1'b0;
    vt[0] = '{16'h0010, 16'h0100, 16'h0001, 3, 1, 3,
              16'h0012, 16'h0100};
    vt[1] = '{16'h00FF, 16'h0000, 16'h0001, 2, 1, 2,
              16'h0100, 16'h0000};
    vt[2] = '{16'h0005, 16'h0000, 16'h0002, 2, 2, 4,
              16'h0007, 16'hFFFE};
    vt[3] = '{16'hFFFF, 16'h8000, 16'h0003, 1, 3, 3,
              16'hFFFF, 16'h7FFA};

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", enter.enter_valid, 0);
    chk("rst_start", enter.enter_start, 0);
    chk("rst_busy", ctl_busy, 0);
    chk("rst_done", ctl_done, 0);
    chk("rst_sts", sts, 0);
    chk("rst_ab_tag", {enter.enter_a, enter.enter_b,
                       enter.enter_tag}, 0);
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_scan(vt[i].a0, vt[i].b0, vt[i].st,
               vt[i].w, vt[i].h, 0);
      chk("tbl_count", got.size(), vt[i].n);
      if (got.size() > 0) begin
        chk("tbl_last_a", got[got.size()-1].a, vt[i].la);
        chk("tbl_last_b", got[got.size()-1].b, vt[i].lb);
      end
    end

    run_scan(16'h0010, 16'h0100, 16'h0001, 2, 1, 2);
    run_scan(16'h1234, 16'h0000, 16'h0001, 0, 2, 0);
    run_scan(16'h1234, 16'h0000, 16'h0001, 3, 0, 0);

    // reset in the middle of a burst
    @(negedge clk);
    cfg_a0 = 16'h0040; cfg_b0 = 16'h0000;
    cfg_step = 16'h0001;
    cfg_width = XW'(4); cfg_height = YW'(1);
    ctl_start = 1'b1;
    @(negedge clk);
    ctl_start = 1'b0;
    wcnt = 0;
    while (!(enter.enter_valid && enter.enter_start)
           && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    chk("rst_burst_seen", enter.enter_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_valid", enter.enter_valid, 0);
    chk("async_busy", ctl_busy, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_sts", sts, 0);
    chk("post_rst_valid", enter.enter_valid, 0);
    run_scan(16'h0003, 16'h0020, 16'h0010, 2, 2, 0);

    for (int r = 0; r < 8; r++) begin
      run_scan(16'($urandom), 16'($urandom),
               16'($urandom),
               $urandom_range(1, 4), $urandom_range(1, 3),
               $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
